pxs_timing_gen: RTL and testbench

PXS_TIMING_GEN -- requirements
Module: pxs_timing_gen

---
 rtl/pxs_timing_gen_pkg.sv | 32 +++
 rtl/pxs_timing_gen_if.sv | 10 +
 rtl/pxs_axis_counter.sv | 25 ++
 rtl/pxs_timing_gen.sv | 92 +++++++++
 tb/tb_pxs_timing_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pxs_timing_gen_pkg.sv
// Shared pixel-stream definitions: stream word field positions and default 640x480 timing.
package pxs_timing_gen_pkg;

  localparam int unsigned PXS_W      = 26;
  localparam int unsigned XC_MSB     = 25;
  localparam int unsigned XC_LSB     = 16;
  localparam int unsigned YC_MSB     = 15;
  localparam int unsigned YC_LSB     = 6;
  localparam int unsigned HS_BIT     = 5;
  localparam int unsigned VS_BIT     = 4;
  localparam int unsigned ACTIVE_BIT = 3;
  localparam int unsigned RGB_MSB    = 2;
  localparam int unsigned RGB_LSB    = 0;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Idle word: origin position, both syncs inactive (high), blanked.
  localparam logic [PXS_W-1:0] PXS_RESET_WORD = PXS_W'((1 << HS_BIT) | (1 << VS_BIT));

  // Eight vertical colour bars, 80 pixels wide.
  function automatic logic [2:0] pxs_bar_color(input logic [9:0] xc);
    return 3'(xc / 10'd80);
  endfunction

endpackage

// File: rtl/pxs_timing_gen_if.sv
// Pixel-stream bundle: control inputs and the produced stream word / frame marker.
interface pxs_timing_gen_if;
  logic        px_en;
  logic [2:0]  bg_color;
  logic [25:0] RGBStr_o;
  logic        frame_start;

  modport master (input px_en, input bg_color, output RGBStr_o, output frame_start);
  modport slave  (output px_en, output bg_color, input RGBStr_o, input frame_start);
endinterface

// File: rtl/pxs_axis_counter.sv
// Wrapping position counter for one screen axis, with enable, wrap pulse and sync reset.
module pxs_axis_counter #(
  parameter int unsigned TOTAL = 800
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [9:0] o_count,
  output logic       o_wrap
);

  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  logic [9:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_count <= '0;
    else if (o_wrap) r_count <= '0;
    else if (i_en)   r_count <= r_count + 10'd1;
  end

endmodule

// File: rtl/pxs_timing_gen.sv
// Video timing generator producing a registered 26-bit pixel-stream word.
// Optional build macro: PXS_TEST_PATTERN_EN (colour bars instead of bg_color).
module pxs_timing_gen
  import pxs_timing_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        px_en,
  input  logic [2:0]  bg_color,
  output logic [25:0] RGBStr_o,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]       w_xc, w_yc;
  logic             w_h_wrap, w_v_wrap, w_active;
  logic [PXS_W-1:0] w_next;
  logic [PXS_W-1:0] r_word;
  logic             r_frame_start;
  logic             r_at_origin;

  pxs_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .i_clk   (px_clk),
    .i_rst   (reset),
    .i_en    (px_en),
    .o_count (w_xc),
    .o_wrap  (w_h_wrap)
  );

  pxs_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .i_clk   (px_clk),
    .i_rst   (reset),
    .i_en    (w_h_wrap),
    .o_count (w_yc),
    .o_wrap  (w_v_wrap)
  );

  // Counters hold the position to be emitted next; the word is decoded from them.
  assign w_active = (w_xc < H_VIS) && (w_yc < V_VIS);

  always_comb begin
    w_next                   = '0;
    w_next[XC_MSB:XC_LSB]    = w_xc;
    w_next[YC_MSB:YC_LSB]    = w_yc;
    w_next[HS_BIT]           = !((w_xc >= HS_BEG) && (w_xc < HS_END));
    w_next[VS_BIT]           = !((w_yc >= VS_BEG) && (w_yc < VS_END));
    w_next[ACTIVE_BIT]       = w_active;
    if (w_active) begin
`ifdef PXS_TEST_PATTERN_EN
      w_next[RGB_MSB:RGB_LSB] = pxs_bar_color(w_xc);
`else
      w_next[RGB_MSB:RGB_LSB] = bg_color;
`endif
    end
  end

  // r_at_origin tracks "counters sit at (0,0)", so the pulse fires on the word that emits the origin.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_word        <= PXS_RESET_WORD;
      r_frame_start <= 1'b0;
      r_at_origin   <= 1'b1;
    end else begin
      r_frame_start <= px_en && r_at_origin;
      if (px_en) r_word <= w_next;
      if (w_v_wrap)   r_at_origin <= 1'b1;
      else if (px_en) r_at_origin <= 1'b0;
    end
  end

  assign RGBStr_o    = r_word;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_pxs_timing_gen.sv
// Directed + randomized bench for pxs_timing_gen against a frame-position reference model.
module tb_pxs_timing_gen;

  localparam int unsigned HV = 160, HF = 8, HSY = 16, HB = 8;
  localparam int unsigned VV = 40,  VF = 3, VSY = 2,  VB = 5;
  localparam int unsigned HT = HV + HF + HSY + HB;
  localparam int unsigned VT = VV + VF + VSY + VB;
  localparam int unsigned FT = HT * VT;
  localparam logic [25:0] RST_WORD = 26'h30;

  logic clk;
  logic reset;
  pxs_timing_gen_if bus ();

  pxs_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .px_clk      (clk),
    .reset       (reset),
    .px_en       (bus.px_en),
    .bg_color    (bus.bg_color),
    .RGBStr_o    (bus.RGBStr_o),
    .frame_start (bus.frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned m_pos = 0;
  logic [25:0] m_word = RST_WORD;
  logic        m_fs = 1'b0;
  int unsigned since_fs = 0, last_period = 0;
  bit          seen_fs = 0;
  int unsigned hs_low = 0, vs_low = 0, act_cnt = 0;

  // Expected word for linear frame position pos, straight from the timing rules.
  function automatic logic [25:0] word_at(input int unsigned pos, input logic [2:0] bg);
    int unsigned x, y;
    logic act, hs, vs;
    logic [2:0] rgb;
    x   = pos % HT;
    y   = pos / HT;
    act = (x < HV) && (y < VV);
    hs  = !((x >= HV + HF) && (x < HV + HF + HSY));
    vs  = !((y >= VV + VF) && (y < VV + VF + VSY));
`ifdef PXS_TEST_PATTERN_EN
    rgb = act ? 3'(x / 80) : 3'd0;
`else
    rgb = act ? bg : 3'd0;
`endif
    return {10'(x), 10'(y), hs, vs, act, rgb};
  endfunction

  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [2:0] bg);
    @(negedge clk);
    reset = rst; bus.px_en = en; bus.bg_color = bg;
    @(posedge clk);
    if (rst) begin
      m_word = RST_WORD; m_fs = 1'b0; m_pos = 0;
    end else if (en) begin
      m_word = word_at(m_pos, bg);
      m_fs   = (m_pos == 0);
      m_pos  = (m_pos + 1) % FT;
    end else begin
      m_fs = 1'b0;
    end
    #1;
    check("word", bus.RGBStr_o, m_word);
    check("frame_start", 26'(bus.frame_start), 26'(m_fs));
    since_fs++;
    if (bus.frame_start) begin
      if (seen_fs) last_period = since_fs;
      seen_fs = 1; since_fs = 0;
    end
    if (!rst && en) begin
      if (!bus.RGBStr_o[5]) hs_low++;
      if (!bus.RGBStr_o[4]) vs_low++;
      if (bus.RGBStr_o[3]) act_cnt++;
    end
  endtask

  task automatic expire(input string tag);
    n_checks++; n_errors++;
    $error("FAIL %s observed=timeout expected=target reached", tag);
  endtask

  initial begin
    reset = 1'b1; bus.px_en = 1'b0; bus.bg_color = 3'd0;

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 3'($urandom));

    // Reset exit: first word is the origin with frame_start.
    hs_low = 0; vs_low = 0; act_cnt = 0; seen_fs = 0; since_fs = 0;
    cyc(1'b0, 1'b1, 3'd5);
    check("first_xy", 26'(bus.RGBStr_o[25:6]), 26'd0);
    check("first_active", 26'(bus.RGBStr_o[3]), 26'd1);
    check("first_fs", 26'(bus.frame_start), 26'd1);
    cyc(1'b0, 1'b1, 3'($urandom));
    check("second_xc", 26'(bus.RGBStr_o[25:16]), 26'd1);

    // One full frame; then the next frame_start closes the period.
    for (int unsigned i = 2; i < FT; i++) cyc(1'b0, 1'b1, 3'($urandom));
    check("hs_low_frame", 26'(hs_low), 26'(VT * HSY));
    check("vs_low_frame", 26'(vs_low), 26'(VSY * HT));
    check("active_frame", 26'(act_cnt), 26'(HV * VV));
    cyc(1'b0, 1'b1, 3'($urandom));
    check("frame_period", 26'(last_period), 26'(FT));

    // Alternate px_en every cycle: frame period doubles.
    cyc(1'b1, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0);
    seen_fs = 0; since_fs = 0; last_period = 0;
    for (int unsigned i = 0; i < 2 * FT + 4; i++) cyc(1'b0, (i % 2) == 0, 3'($urandom));
    check("toggle_period", 26'(last_period), 26'(2 * FT));

    // Randomized enable/background with occasional reset.
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 600) == 0, ($urandom % 3) != 0, 3'($urandom));

    // Mid-frame reset at (100,20) abandons the frame.
    begin
      int unsigned guard = 0;
      while (!(m_word[25:16] == 10'd100 && m_word[15:6] == 10'd20) && guard < 2 * FT) begin
        cyc(1'b0, 1'b1, 3'($urandom));
        guard++;
      end
      if (guard >= 2 * FT) expire("reach_100_20");
    end
    cyc(1'b1, 1'b1, 3'd5);
    check("midreset_word", bus.RGBStr_o, RST_WORD);
    cyc(1'b0, 1'b1, 3'd5);
    check("restart_fs", 26'(bus.frame_start), 26'd1);
    check("restart_xy", 26'(bus.RGBStr_o[25:6]), 26'd0);
`ifndef PXS_TEST_PATTERN_EN
    check("rgb_bg_origin", 26'(bus.RGBStr_o[2:0]), 26'd5);
`endif

    // Colour at the visible-area boundary columns of line 0.
    begin
      int unsigned guard = 0;
      while (m_word[25:16] != 10'(HV) && guard < 2 * HT) begin
        cyc(1'b0, 1'b1, 3'd5);
`ifdef PXS_TEST_PATTERN_EN
        if (m_word[25:16] == 10'd79) check("bar_79", 26'(bus.RGBStr_o[2:0]), 26'd0);
        if (m_word[25:16] == 10'd80) check("bar_80", 26'(bus.RGBStr_o[2:0]), 26'd1);
`endif
        guard++;
      end
      if (guard >= 2 * HT) expire("reach_hvis");
    end
    check("rgb_blank_hvis", 26'(bus.RGBStr_o[2:0]), 26'd0);
    check("active_blank_hvis", 26'(bus.RGBStr_o[3]), 26'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
